// File: rtl/instr_fetch_if.sv
// Fetch-stage bus: instruction-memory handshake plus the decoded-instruction
// hand-off to the control FSM. "master" is the fetch stage, "slave" is its environment.
interface instr_fetch_if;
  // Instruction memory request/acknowledge
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  // Hand-off to the control FSM
  logic        instr_valid;
  logic        next_ready;
  logic        pc_load;
  logic [31:0] pc_target;

  // Decoded MIPS fields of the instruction register
  logic [5:0]  upcode;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [4:0]  shamt;
  logic [5:0]  func;
  logic [15:0] imm;

  logic [31:0] pc;
  logic [31:0] pc_plus4;

  // Status pulses
  logic        align_err;
  logic        fetch_timeout;

  modport master (
    output imem_req, imem_addr,
    input  imem_ack, imem_rdata,
    output instr_valid,
    input  next_ready, pc_load, pc_target,
    output upcode, rs, rt, rd, shamt, func, imm,
    output pc, pc_plus4,
    output align_err, fetch_timeout
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_ack, imem_rdata,
    input  instr_valid,
    output next_ready, pc_load, pc_target,
    input  upcode, rs, rt, rd, shamt, func, imm,
    input  pc, pc_plus4,
    input  align_err, fetch_timeout
  );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC register, req/ack fetch with timeout/retry, instruction
// register and field decode held until the control FSM accepts.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned TIMEOUT  = 16
) (
  input logic           clk,
  input logic           rst,
  instr_fetch_if.master bus
);

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StRetry,
    StHold
  } state_e;

  localparam logic [7:0] CntLast = 8'(TIMEOUT - 1);

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] ir_q;
  logic [7:0]  cnt_q;
  logic        req_q;
  logic        valid_q;
  logic        align_err_q;
  logic        timeout_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      pc_q        <= RESET_PC;
      ir_q        <= 32'h0;
      cnt_q       <= 8'h0;
      req_q       <= 1'b0;
      valid_q     <= 1'b0;
      align_err_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      align_err_q <= 1'b0;
      timeout_q   <= 1'b0;
      case (state_q)
        StIdle: begin
          req_q   <= 1'b1;
          state_q <= StReq;
        end
        StReq: begin
          if (bus.imem_ack) begin
            ir_q    <= bus.imem_rdata;
            cnt_q   <= 8'h0;
            req_q   <= 1'b0;
            valid_q <= 1'b1;
            state_q <= StHold;
          end else if (cnt_q == CntLast) begin
            cnt_q     <= 8'h0;
            req_q     <= 1'b0;
            timeout_q <= 1'b1;
            state_q   <= StRetry;
          end else begin
            cnt_q <= cnt_q + 8'h1;
          end
        end
        StRetry: begin
          cnt_q   <= 8'h0;
          req_q   <= 1'b1;
          state_q <= StReq;
        end
        StHold: begin
          if (bus.next_ready) begin
            valid_q <= 1'b0;
            req_q   <= 1'b1;
            state_q <= StReq;
            // Redirect targets are forced word-aligned; a misaligned one is flagged.
            if (bus.pc_load) begin
              pc_q        <= {bus.pc_target[31:2], 2'b00};
              align_err_q <= |bus.pc_target[1:0];
            end else begin
              pc_q <= pc_q + 32'd4;
            end
          end
        end
        default: begin
          req_q   <= 1'b0;
          valid_q <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign bus.imem_req      = req_q;
  assign bus.imem_addr     = pc_q;
  assign bus.instr_valid   = valid_q;
  assign bus.align_err     = align_err_q;
  assign bus.fetch_timeout = timeout_q;

  assign bus.upcode   = ir_q[31:26];
  assign bus.rs       = ir_q[25:21];
  assign bus.rt       = ir_q[20:16];
  assign bus.rd       = ir_q[15:11];
  assign bus.shamt    = ir_q[10:6];
  assign bus.func     = ir_q[5:0];
  assign bus.imm      = ir_q[15:0];
  assign bus.pc       = pc_q;
  assign bus.pc_plus4 = pc_q + 32'd4;

  a_req_valid_excl: assert property (@(posedge clk) disable iff (rst) !(req_q && valid_q));
  a_pc_aligned:     assert property (@(posedge clk) disable iff (rst) pc_q[1:0] == 2'b00);

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: stimulus pushes expected fetches/pulses into queues,
// a negedge monitor pops and compares whenever the DUT presents them.
module tb_instr_fetch;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst1 = 1'b1;

  always #5 clk = ~clk;

  instr_fetch_if bus ();
  instr_fetch_if bus1 ();

  instr_fetch #(
    .RESET_PC(32'h0000_0000),
    .TIMEOUT (16)
  ) u_dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  instr_fetch #(
    .RESET_PC(32'hFFFF_FFFC),
    .TIMEOUT (16)
  ) u_dut_wrap (
    .clk(clk),
    .rst(rst1),
    .bus(bus1)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] word;
  } fetch_t;

  fetch_t      exp_q[$];
  logic [31:0] align_q[$];
  logic [31:0] tmo_q[$];

  int n_vec = 0;
  int n_mis = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare each newly presented instruction and each status pulse.
  logic prev_valid = 1'b0;
  logic prev_align = 1'b0;
  logic prev_tmo   = 1'b0;

  always @(negedge clk) begin
    fetch_t e;
    logic [31:0] a;
    if (rst) begin
      prev_valid = 1'b0;
      prev_align = 1'b0;
      prev_tmo   = 1'b0;
    end else begin
      if (bus.instr_valid && !prev_valid) begin
        if (exp_q.size() == 0) begin
          n_vec++; n_mis++;
          $display("FAIL unexpected_instr: pc 0x%08h with no fetch outstanding", bus.pc);
        end else begin
          e = exp_q.pop_front();
          check("sb_pc",       bus.pc,                e.addr);
          check("sb_pc_plus4", bus.pc_plus4,          e.addr + 32'd4);
          check("sb_upcode",   32'(bus.upcode),       32'(e.word[31:26]));
          check("sb_rs",       32'(bus.rs),           32'(e.word[25:21]));
          check("sb_rt",       32'(bus.rt),           32'(e.word[20:16]));
          check("sb_rd",       32'(bus.rd),           32'(e.word[15:11]));
          check("sb_shamt",    32'(bus.shamt),        32'(e.word[10:6]));
          check("sb_func",     32'(bus.func),         32'(e.word[5:0]));
          check("sb_imm",      32'(bus.imm),          32'(e.word[15:0]));
        end
      end
      if (bus.align_err) begin
        if (align_q.size() == 0) begin
          n_vec++; n_mis++;
          $display("FAIL unexpected_align_err: addr 0x%08h, none expected", bus.imem_addr);
        end else begin
          a = align_q.pop_front();
          check("sb_align_addr", bus.imem_addr, a);
        end
        if (prev_align) check("align_err_width", 32'(bus.align_err), 32'd0);
      end
      if (bus.fetch_timeout) begin
        if (tmo_q.size() == 0) begin
          n_vec++; n_mis++;
          $display("FAIL unexpected_timeout: addr 0x%08h, none expected", bus.imem_addr);
        end else begin
          a = tmo_q.pop_front();
          check("sb_timeout_addr", bus.imem_addr, a);
        end
        if (prev_tmo) check("timeout_width", 32'(bus.fetch_timeout), 32'd0);
      end
      prev_valid = bus.instr_valid;
      prev_align = bus.align_err;
      prev_tmo   = bus.fetch_timeout;
    end
  end

  task automatic wait_req(output bit ok);
    int n = 0;
    @(negedge clk);
    while (!bus.imem_req && n < 64) begin
      @(negedge clk);
      n++;
    end
    ok = bus.imem_req;
    if (!ok) begin
      n_vec++; n_mis++;
      $display("FAIL wait_req: imem_req never rose within 64 cycles at %0t", $time);
    end
  endtask

  // Answer the next request after `delay` wait cycles, scrambling rdata while waiting.
  task automatic serve(input logic [31:0] addr, input logic [31:0] word, input int delay);
    bit ok;
    wait_req(ok);
    if (!ok) return;
    for (int i = 0; i < delay; i++) begin
      check("req_stable",  32'(bus.imem_req), 32'd1);
      check("addr_stable", bus.imem_addr,     addr);
      bus.imem_ack   = 1'b0;
      bus.imem_rdata = $urandom;
      @(negedge clk);
    end
    check("req",          32'(bus.imem_req),    32'd1);
    check("addr",         bus.imem_addr,        addr);
    check("valid_in_req", 32'(bus.instr_valid), 32'd0);
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = word;
    exp_q.push_back('{addr: addr, word: word});
    @(posedge clk);
    #1;
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = 32'hDEAD_BEEF;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = 32'h0;
    bus.next_ready = 1'b1;
    bus.pc_load    = 1'b0;
    bus.pc_target  = 32'h0;
    bus1.imem_ack   = 1'b1;
    bus1.imem_rdata = 32'h1234_5678;
    bus1.next_ready = 1'b1;
    bus1.pc_load    = 1'b0;
    bus1.pc_target  = 32'h0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req",     32'(bus.imem_req),      32'd0);
    check("rst_valid",   32'(bus.instr_valid),   32'd0);
    check("rst_align",   32'(bus.align_err),     32'd0);
    check("rst_timeout", 32'(bus.fetch_timeout), 32'd0);
    check("rst_pc",      bus.pc,                 32'h0);
    check("rst_ir",      32'(bus.imm),           32'd0);
    rst = 1'b0;

    // Back-to-back single-cycle fetches
    serve(32'h0000_0000, 32'h0123_4820, 0);
    @(negedge clk);
    check("a_valid",  32'(bus.instr_valid), 32'd1);
    check("a_req",    32'(bus.imem_req),    32'd0);
    check("a_upcode", 32'(bus.upcode),      32'd0);
    check("a_rs",     32'(bus.rs),          32'd9);
    check("a_rt",     32'(bus.rt),          32'd3);
    check("a_rd",     32'(bus.rd),          32'd9);
    check("a_shamt",  32'(bus.shamt),       32'd0);
    check("a_func",   32'(bus.func),        32'h20);
    serve(32'h0000_0004, 32'h8C22_0010, 0);
    @(negedge clk);
    check("b_valid", 32'(bus.instr_valid), 32'd1);
    serve(32'h0000_0008, 32'hAC43_FFFC, 0);

    // Delayed ack, then a 5-cycle stall with ignored acks during HOLD
    @(posedge clk);
    #1;
    bus.next_ready = 1'b0;
    serve(32'h0000_000C, 32'h2001_0005, 3);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_valid",  32'(bus.instr_valid), 32'd1);
      check("stall_req",    32'(bus.imem_req),    32'd0);
      check("stall_pc",     bus.pc,               32'h0000_000C);
      check("stall_upcode", 32'(bus.upcode),      32'h08);
      check("stall_rt",     32'(bus.rt),          32'd1);
      check("stall_imm",    32'(bus.imm),         32'h0005);
      bus.imem_ack   = 1'b1;
      bus.imem_rdata = $urandom;
    end
    bus.imem_ack   = 1'b0;
    bus.next_ready = 1'b1;
    serve(32'h0000_0010, 32'h0800_0040, 0);

    // Misaligned redirect, then an aligned one; pc_load held high through REQ is ignored
    bus.pc_load   = 1'b1;
    bus.pc_target = 32'h0000_0102;
    align_q.push_back(32'h0000_0100);
    serve(32'h0000_0100, 32'h1111_2222, 1);
    bus.pc_target = 32'h0000_0040;
    @(posedge clk);
    #1;
    bus.pc_load = 1'b0;
    serve(32'h0000_0040, 32'h3C08_ABCD, 0);

    // No ack for TIMEOUT cycles: one-cycle retry gap, then same address again
    tmo_q.push_back(32'h0000_0044);
    wait_req(ok);
    for (int i = 0; i < 16; i++) begin
      check("tmo_req",  32'(bus.imem_req),      32'd1);
      check("tmo_addr", bus.imem_addr,          32'h0000_0044);
      check("tmo_early", 32'(bus.fetch_timeout), 32'd0);
      @(negedge clk);
    end
    check("retry_req",   32'(bus.imem_req),      32'd0);
    check("retry_pulse", 32'(bus.fetch_timeout), 32'd1);
    @(negedge clk);
    check("reissue_req",  32'(bus.imem_req),      32'd1);
    check("reissue_addr", bus.imem_addr,          32'h0000_0044);
    check("reissue_tmo",  32'(bus.fetch_timeout), 32'd0);
    serve(32'h0000_0044, 32'h0274_8822, 2);

    // Reset during a waiting REQ; the same-cycle ack must be discarded
    wait_req(ok);
    check("prerst_addr", bus.imem_addr, 32'h0000_0048);
    @(negedge clk);
    rst            = 1'b1;
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    check("midrst_req",   32'(bus.imem_req),    32'd0);
    check("midrst_valid", 32'(bus.instr_valid), 32'd0);
    check("midrst_pc",    bus.pc,               32'h0);
    check("midrst_ir",    32'(bus.imm),         32'd0);
    rst          = 1'b0;
    bus.imem_ack = 1'b0;
    serve(32'h0000_0000, 32'h0000_000C, 0);

    // PC wrap from 0xFFFF_FFFC with an always-acking memory
    @(negedge clk);
    rst1 = 1'b0;
    @(negedge clk);
    check("wrap_req0",   32'(bus1.imem_req), 32'd1);
    check("wrap_addr0",  bus1.imem_addr,     32'hFFFF_FFFC);
    @(negedge clk);
    check("wrap_valid",  32'(bus1.instr_valid), 32'd1);
    check("wrap_pc",     bus1.pc,               32'hFFFF_FFFC);
    check("wrap_plus4",  bus1.pc_plus4,         32'h0);
    check("wrap_imm",    32'(bus1.imm),         32'h5678);
    @(negedge clk);
    check("wrap_req1",   32'(bus1.imem_req), 32'd1);
    check("wrap_addr1",  bus1.imem_addr,     32'h0);

    repeat (3) @(negedge clk);
    check("drain_instr", exp_q.size(),   32'd0);
    check("drain_align", align_q.size(), 32'd0);
    check("drain_tmo",   tmo_q.size(),   32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
